// File: rtl/seg_scan_if.sv
// Score/combo input and segment/anode output bundle of the scan driver.
// The master side is the game logic and display; the slave side is the driver.
interface seg_scan_if;
    logic [13:0] score;
    logic [6:0]  combo;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        busy;

    modport master (output score, combo, input seg, an, busy);
    modport slave  (input score, combo, output seg, an, busy);
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver for score/combo: sequential
// double-dabble BCD conversion, leading-zero suppression, anti-ghost blanking.
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic      clk_50m,
    input  logic      rst_n,
    input  logic      clk_seg,
    seg_scan_if.slave bus
);
    localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    function automatic logic [3:0] dd_nib(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Scan clock synchronizer and both-edge detector
    logic seg_meta_q, seg_sync_q, seg_dly_q;
    logic scan_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= 1'b0;
            seg_sync_q <= 1'b0;
            seg_dly_q  <= 1'b0;
        end else begin
            seg_meta_q <= clk_seg;
            seg_sync_q <= seg_meta_q;
            seg_dly_q  <= seg_sync_q;
        end
    end

    assign scan_edge = seg_sync_q ^ seg_dly_q;

    // BCD converter
    conv_state_e state_q, state_d;
    logic [13:0] sat_score, last_score_q, last_score_d;
    logic [6:0]  sat_combo, last_combo_q, last_combo_d;
    logic [13:0] sh_score_q, sh_score_d, sh_combo_q, sh_combo_d;
    logic [15:0] bcd_score_q, bcd_score_d, disp_score_q, disp_score_d;
    logic [7:0]  bcd_combo_q, bcd_combo_d, disp_combo_q, disp_combo_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] adj_score;
    logic [7:0]  adj_combo;
    logic [29:0] score_shift;
    logic [21:0] combo_shift;

    assign sat_score = (bus.score > 14'd9999) ? 14'd9999 : bus.score;
    assign sat_combo = (bus.combo > 7'd99) ? 7'd99 : bus.combo;

    assign adj_score = {dd_nib(bcd_score_q[15:12]), dd_nib(bcd_score_q[11:8]),
                        dd_nib(bcd_score_q[7:4]),   dd_nib(bcd_score_q[3:0])};
    assign adj_combo = {dd_nib(bcd_combo_q[7:4]), dd_nib(bcd_combo_q[3:0])};
    assign score_shift = {adj_score, sh_score_q} << 1;
    assign combo_shift = {adj_combo, sh_combo_q} << 1;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        last_combo_d = last_combo_q;
        sh_score_d   = sh_score_q;
        sh_combo_d   = sh_combo_q;
        bcd_score_d  = bcd_score_q;
        bcd_combo_d  = bcd_combo_q;
        iter_d       = iter_q;
        disp_score_d = disp_score_q;
        disp_combo_d = disp_combo_q;
        case (state_q)
            ST_IDLE: begin
                if (sat_score != last_score_q || sat_combo != last_combo_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                last_score_d = sat_score;
                last_combo_d = sat_combo;
                sh_score_d   = sat_score;
                sh_combo_d   = 14'(sat_combo);
                bcd_score_d  = '0;
                bcd_combo_d  = '0;
                iter_d       = 4'd14;
                state_d      = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_score_d = score_shift[29:14];
                sh_score_d  = score_shift[13:0];
                bcd_combo_d = combo_shift[21:14];
                sh_combo_d  = combo_shift[13:0];
                iter_d      = iter_q - 4'd1;
                if (iter_q == 4'd1) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Both display registers swap in one edge so a scan step never mixes old and new.
                disp_score_d = bcd_score_q;
                disp_combo_d = bcd_combo_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_score_q <= '0;
            last_combo_q <= '0;
            sh_score_q   <= '0;
            sh_combo_q   <= '0;
            bcd_score_q  <= '0;
            bcd_combo_q  <= '0;
            iter_q       <= '0;
            disp_score_q <= '0;
            disp_combo_q <= '0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            last_combo_q <= last_combo_d;
            sh_score_q   <= sh_score_d;
            sh_combo_q   <= sh_combo_d;
            bcd_score_q  <= bcd_score_d;
            bcd_combo_q  <= bcd_combo_d;
            iter_q       <= iter_d;
            disp_score_q <= disp_score_d;
            disp_combo_q <= disp_combo_d;
        end
    end

    assign bus.busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

    // Digit scan with anti-ghost blanking
    logic [2:0]       idx_q, idx_d, nxt_idx;
    logic [7:0]       seg_q, seg_d, nxt_code;
    logic [5:0]       an_q, an_d;
    logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic             blanking_q, blanking_d;
    logic [3:0]       nib;
    logic             nib_blank;

    always_comb begin
        nxt_idx   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        nib       = '0;
        nib_blank = 1'b1;
        case (nxt_idx)
            3'd0: begin nib = disp_score_q[3:0];   nib_blank = 1'b0; end
            3'd1: begin nib = disp_score_q[7:4];   nib_blank = (disp_score_q[15:4] == '0); end
            3'd2: begin nib = disp_score_q[11:8];  nib_blank = (disp_score_q[15:8] == '0); end
            3'd3: begin nib = disp_score_q[15:12]; nib_blank = (disp_score_q[15:12] == '0); end
            3'd4: begin nib = disp_combo_q[3:0];   nib_blank = (disp_combo_q == '0); end
            3'd5: begin nib = disp_combo_q[7:4];   nib_blank = (disp_combo_q[7:4] == '0); end
            default: ;
        endcase
        nxt_code = nib_blank ? 8'hFF : seg_code(nib);
        if (nxt_idx == 3'd0) nxt_code[7] = 1'b0;

        idx_d       = idx_q;
        seg_d       = seg_q;
        an_d        = an_q;
        blank_cnt_d = blank_cnt_q;
        blanking_d  = blanking_q;
        if (scan_edge) begin
            idx_d = nxt_idx;
            seg_d = nxt_code;
            if (BLANK_CYCLES == 0) begin
                an_d = ~(6'd1 << nxt_idx);
            end else begin
                an_d        = 6'h3F;
                blank_cnt_d = BLANK_LOAD;
                blanking_d  = 1'b1;
            end
        end else if (blanking_q) begin
            if (blank_cnt_q == '0) begin
                an_d       = ~(6'd1 << idx_q);
                blanking_d = 1'b0;
            end else begin
                blank_cnt_d = blank_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            seg_q       <= 8'hFF;
            an_q        <= 6'h3F;
            blank_cnt_q <= '0;
            blanking_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            blank_cnt_q <= blank_cnt_d;
            blanking_q  <= blanking_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: table vectors, hand-timed corner sequences and
// random score/combo values against an arithmetic digit/blanking model.
module tb_seg_scan_driver;
    localparam int BLANK = 64;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic clk_seg = 1'b0;

    always #5 clk_50m = ~clk_50m;

    seg_scan_if bus ();
    seg_scan_if bus0 ();
    assign bus0.score = bus.score;
    assign bus0.combo = bus.combo;

    seg_scan_driver #(.BLANK_CYCLES(BLANK)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .clk_seg(clk_seg), .bus(bus)
    );
    seg_scan_driver #(.BLANK_CYCLES(0)) dut_nob (
        .clk_50m(clk_50m), .rst_n(rst_n), .clk_seg(clk_seg), .bus(bus0)
    );

    int total = 0;
    int bad   = 0;
    int idx_m = 0;
    bit prev_lit = 1'b0;

    typedef struct packed {
        logic [13:0] score;
        logic [6:0]  combo;
        logic [47:0] exp;   // seg code per index, index 0 in the low byte
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, val, lo, hi, $time);
        end
    endtask

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected code of one digit from the decimal value and the blanking rules.
    function automatic logic [7:0] model_seg(input int s_raw, input int c_raw, input int idx);
        int s;
        int c;
        int p10 [4];
        logic [7:0] r;
        bit blank;
        p10 = '{1, 10, 100, 1000};
        s = (s_raw > 9999) ? 9999 : s_raw;
        c = (c_raw > 99) ? 99 : c_raw;
        if (idx < 4) begin
            blank = (idx > 0) && (s < p10[idx]);
            r = code_of((s / p10[idx]) % 10);
        end else begin
            blank = (c == 0) || (idx == 5 && c < 10);
            r = code_of((idx == 4) ? c % 10 : c / 10);
        end
        if (blank) r = 8'hFF;
        if (idx == 0) r[7] = 1'b0;
        return r;
    endfunction

    function automatic logic [47:0] model_all(input int s, input int c);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = model_seg(s, c, i);
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Completes one scan step whose clk_seg toggle happened pre cycles ago.
    task automatic finish_step(input logic [47:0] exp48, input int pre, input bit chk_blank);
        logic [7:0] exp_seg;
        logic [5:0] exp_an;
        int lat;
        int n3f;
        int lat0;
        bit done;
        idx_m   = (idx_m == 5) ? 0 : idx_m + 1;
        exp_an  = ~(6'd1 << idx_m);
        exp_seg = exp48[8*idx_m +: 8];
        lat = pre;
        n3f = 0;
        lat0 = -1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk_50m);
            lat++;
            if (bus.an == 6'h3F) n3f++;
            if (lat0 < 0 && bus0.an == exp_an) lat0 = lat;
            if (bus.an == exp_an) done = 1'b1;
        end
        check("anode_select", 48'(bus.an), 48'(exp_an));
        check_range("scan_latency", lat, BLANK + 1, BLANK + 3);
        if (chk_blank) check("blank_cycles", 48'(n3f), 48'(BLANK));
        if (pre == 0) check_range("noblank_latency", lat0, 1, 3);
        check("seg_code", 48'(bus.seg), 48'(exp_seg));
        check("seg_code_noblank", 48'(bus0.seg), 48'(exp_seg));
        check("anode_noblank", 48'(bus0.an), 48'(exp_an));
        prev_lit = 1'b1;
    endtask

    task automatic scan_all(input logic [47:0] exp48);
        for (int i = 0; i < 6; i++) begin
            clk_seg = ~clk_seg;
            finish_step(exp48, 0, prev_lit);
        end
    endtask

    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk_50m);
            if (bus.busy) seen = 1'b1;
        end
    endtask

    task automatic apply(input int s, input int c, output int run);
        bit seen;
        bus.score = 14'(s);
        bus.combo = 7'(c);
        run = 0;
        wait_busy(seen);
        if (seen) begin
            run = 1;
            for (int k = 0; k < 40 && bus.busy; k++) begin
                @(negedge clk_50m);
                if (bus.busy) run++;
            end
        end
        cyc(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int run;
        bit seen;
        int r1, gap, r2, ph, el;
        bit tog;

        tbl[0] = '{14'd0,     7'd0,   48'hFF_FF_FF_FF_FF_40};
        tbl[1] = '{14'd1234,  7'd56,  48'h92_82_F9_A4_B0_19};
        tbl[2] = '{14'd7,     7'd5,   48'hFF_92_FF_FF_FF_78};
        tbl[3] = '{14'd12000, 7'd120, 48'h90_90_90_90_90_10};
        tbl[4] = '{14'd10,    7'd10,  48'hF9_C0_FF_FF_F9_40};
        tbl[5] = '{14'd9999,  7'd99,  48'h90_90_90_90_90_10};
        tbl[6] = '{14'd1000,  7'd90,  48'h90_C0_F9_C0_C0_40};
        tbl[7] = '{14'd305,   7'd7,   48'hFF_F8_FF_B0_C0_12};

        bus.score = '0;
        bus.combo = '0;
        cyc(3);
        check("reset_seg", 48'(bus.seg), 48'hFF);
        check("reset_an", 48'(bus.an), 48'h3F);
        check("reset_busy", 48'(bus.busy), 48'h0);
        check("reset_an_noblank", 48'(bus0.an), 48'h3F);
        rst_n = 1'b1;
        cyc(20);
        check("dark_until_edge", 48'(bus.an), 48'h3F);
        check("idle_busy", 48'(bus.busy), 48'h0);

        for (int i = 0; i < 8; i++) begin
            apply(int'(tbl[i].score), int'(tbl[i].combo), run);
            if (i > 0) check("busy_len", 48'(run), 48'd15);
            scan_all(tbl[i].exp);
        end

        // Scan step landing on the COMMIT edge shows the old value, the next step the new one.
        bus.score = 14'd5678;
        bus.combo = 7'd12;
        wait_busy(seen);
        check("busy_rise_commit", 48'(seen), 48'h1);
        cyc(13);
        clk_seg = ~clk_seg;
        finish_step(model_all(305, 7), 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            clk_seg = ~clk_seg;
            finish_step(model_all(5678, 12), 0, 1'b1);
        end

        // Input change mid-conversion: first COMMIT shows 100, a second conversion follows.
        bus.score = 14'd100;
        wait_busy(seen);
        check("busy_rise_100", 48'(seen), 48'h1);
        r1 = 1; gap = 0; r2 = 0; ph = 0; el = 0; tog = 1'b0;
        for (int k = 0; k < 80 && ph < 3; k++) begin
            @(negedge clk_50m);
            if (tog) el++;
            if (k == 2) bus.score = 14'd200;
            case (ph)
                0: if (bus.busy) r1++;
                   else begin ph = 1; gap = 1; clk_seg = ~clk_seg; tog = 1'b1; end
                1: if (!bus.busy) gap++;
                   else begin ph = 2; r2 = 1; end
                default: if (bus.busy) r2++;
                         else ph = 3;
            endcase
        end
        check("busy_len_first", 48'(r1), 48'd15);
        check_range("busy_regap", gap, 1, 2);
        check("busy_len_second", 48'(r2), 48'd15);
        finish_step(model_all(100, 12), el, 1'b0);
        scan_all(model_all(200, 12));

        // Reset during SHIFT iteration 7 aborts, then a full conversion follows.
        bus.score = 14'd4321;
        bus.combo = 7'd77;
        wait_busy(seen);
        check("busy_rise_rst", 48'(seen), 48'h1);
        cyc(7);
        rst_n = 1'b0;
        clk_seg = 1'b0;
        #1;
        check("abort_seg", 48'(bus.seg), 48'hFF);
        check("abort_an", 48'(bus.an), 48'h3F);
        check("abort_busy", 48'(bus.busy), 48'h0);
        check("abort_seg_noblank", 48'(bus0.seg), 48'hFF);
        cyc(3);
        rst_n = 1'b1;
        idx_m = 0;
        prev_lit = 1'b0;
        apply(4321, 77, run);
        check("busy_len_after_rst", 48'(run), 48'd15);
        scan_all(model_all(4321, 77));

        for (int r = 0; r < 6; r++) begin
            int s;
            int c;
            s = int'($urandom_range(0, 16383));
            c = int'($urandom_range(0, 127));
            apply(s, c, run);
            if (run != 0) check("busy_len_rand", 48'(run), 48'd15);
            scan_all(model_all(s, c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
